// File: rtl/alu_stim_gen.sv
// Stimulus driver and result checker for the registered 4-bit signed ALU.
// Streams LFSR operands with rotating opcodes and compares C one cycle later.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | outputs parked at zero, waiting for start
//   S_RUN   | one vector per cycle, vec_count is the index being driven
//   S_FLUSH | no new vector; last outstanding result is compared
//   S_DONE  | one-cycle done pulse, counts held until the next start
module alu_stim_gen #(
    parameter int         NUM_VECTORS = 16,
    parameter logic [7:0] SEED        = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [1:0]        Opcode,
    output logic signed [3:0] A,
    output logic signed [3:0] B,
    input  logic signed [4:0] C,
    output logic              mismatch,
    output logic [7:0]        err_count,
    output logic [7:0]        vec_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [7:0] LAST_IDX = 8'(NUM_VECTORS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        lfsr;
    logic [7:0]        lfsr_nxt;
    logic [4:0]        exp_c;
    logic [4:0]        exp_nxt;
    logic              exp_valid;

    function automatic logic [4:0] ref_model(input logic [1:0] op,
                                             input logic [3:0] a,
                                             input logic [3:0] b);
        logic [4:0] sa;
        logic [4:0] sb;
        sa = {a[3], a};
        sb = {b[3], b};
        case (op)
            2'b00:   return sa + sb;
            2'b01:   return sa - sb;
            2'b10:   return ~sa;
            default: return {4'b0000, |b};
        endcase
    endfunction

    assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        Opcode    = 2'b00;
        A         = 4'sd0;
        B         = 4'sd0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy   = 1'b1;
                Opcode = vec_count[1:0];
                A      = lfsr[3:0];
                B      = lfsr[7:4];
                if (vec_count == LAST_IDX) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign exp_nxt = ref_model(Opcode, A, B);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            mismatch  <= 1'b0;
            err_count <= 8'd0;
            vec_count <= 8'd0;
            lfsr      <= SEED_EFF;
            exp_c     <= 5'd0;
            exp_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            mismatch <= 1'b0;

            if (exp_valid && (C != exp_c)) begin
                mismatch <= 1'b1;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        err_count <= 8'd0;
                        vec_count <= 8'd0;
                        lfsr      <= SEED_EFF;
                    end
                end
                S_RUN: begin
                    // Expected result travels alongside the vector into the ALU.
                    vec_count <= vec_count + 8'd1;
                    lfsr      <= lfsr_nxt;
                    exp_c     <= exp_nxt;
                    exp_valid <= 1'b1;
                end
                S_FLUSH: begin
                    exp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_stim_gen.sv
// Directed bench for alu_stim_gen: the bench plays the registered ALU, with a
// fault hook, plus a second instance for the 255-vector stuck-C run.
module tb_alu_stim_gen;

    logic              clk = 1'b0;
    logic              reset;
    logic              start1, start2;
    logic              busy1, busy2, done1, done2;
    logic [1:0]        op1, op2;
    logic signed [3:0] a1, a2, b1, b2;
    logic signed [4:0] c1, c2;
    logic              mm1, mm2;
    logic [7:0]        err1, err2, vec1, vec2;
    logic              c_force;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_stim_gen #(.NUM_VECTORS(16), .SEED(8'hA5)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
        .Opcode(op1), .A(a1), .B(b1), .C(c1), .mismatch(mm1),
        .err_count(err1), .vec_count(vec1)
    );

    alu_stim_gen #(.NUM_VECTORS(255), .SEED(8'hA5)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
        .Opcode(op2), .A(a2), .B(b2), .C(c2), .mismatch(mm2),
        .err_count(err2), .vec_count(vec2)
    );

    function automatic logic [4:0] alu_fn(input logic [1:0] op,
                                          input logic [3:0] a,
                                          input logic [3:0] b);
        logic signed [4:0] sa;
        logic signed [4:0] sb;
        sa = $signed({a[3], a});
        sb = $signed({b[3], b});
        if (op == 2'd0) return sa + sb;
        if (op == 2'd1) return sa - sb;
        if (op == 2'd2) return -sa - 5'sd1;
        return (b != 4'd0) ? 5'd1 : 5'd0;
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        logic fb;
        fb = l[7] ^ l[5] ^ l[4] ^ l[3];
        return {l[6:0], fb};
    endfunction

    // Correct registered ALU on dut1, optionally forced to zero for one sample.
    always @(posedge clk) c1 <= c_force ? 5'd0 : alu_fn(op1, a1, b1);
    assign c2 = 5'b10101;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] hand_a[4] = '{4'h5, 4'hA, 4'h5, 4'hA};
    logic [3:0] hand_b[4] = '{4'hA, 4'h4, 4'h9, 4'h2};

    initial begin
        logic       seen;
        int         n;
        int         n_err;
        logic [7:0] l;

        reset = 1'b0; start1 = 1'b1; start2 = 1'b1; c_force = 1'b0;
        repeat (3) step();
        chk("rst_busy", {busy1}, 1'b0);
        chk("rst_done", {done1}, 1'b0);
        chk("rst_op", {op1}, 2'd0);
        chk("rst_a", {a1}, 4'd0);
        chk("rst_b", {b1}, 4'd0);
        chk("rst_err", {err1}, 8'd0);
        chk("rst_vec", {vec1}, 8'd0);
        chk("rst_busy2", {busy2}, 1'b0);
        @(negedge clk);
        reset = 1'b1; start1 = 1'b0; start2 = 1'b0;
        step(); step();

        // Full run, correct ALU: vector i in cycle i+1, done in cycle 18.
        @(negedge clk); start1 = 1'b1;
        step(); start1 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("run_busy", {busy1}, 1'b1);
            chk("run_op", {op1}, i[1:0]);
            chk("run_vec", {vec1}, i[7:0]);
            if (i < 4) begin
                chk("hand_a", {a1}, hand_a[i]);
                chk("hand_b", {b1}, hand_b[i]);
            end
            seen |= mm1;
            step();
        end
        chk("flush_busy", {busy1}, 1'b1);
        chk("flush_op", {op1}, 2'd0);
        chk("flush_done", {done1}, 1'b0);
        seen |= mm1;
        step();
        chk("done_pulse", {done1}, 1'b1);
        chk("done_busy", {busy1}, 1'b0);
        chk("done_vec", {vec1}, 8'd16);
        chk("done_err", {err1}, 8'd0);
        seen |= mm1;
        chk("run_no_mm", {seen}, 1'b0);
        step();
        chk("done_one_cycle", {done1}, 1'b0);
        chk("hold_vec", {vec1}, 8'd16);

        // Fault: vector 2 (Not_A) returns 0 instead of 5'b11010.
        @(negedge clk); start1 = 1'b1;
        step(); start1 = 1'b0;
        step(); step();
        chk("f_op2", {op1}, 2'd2);
        c_force = 1'b1;
        step(); c_force = 1'b0;
        chk("f_mm_before", {mm1}, 1'b0);
        step();
        chk("f_mm_pulse", {mm1}, 1'b1);
        chk("f_err_one", {err1}, 8'd1);
        step();
        chk("f_mm_after", {mm1}, 1'b0);
        n = 0;
        while (!done1 && n < 40) begin step(); n++; end
        chk("f_done", {done1}, 1'b1);
        chk("f_err_end", {err1}, 8'd1);
        chk("f_vec_end", {vec1}, 8'd16);
        step();

        // Reset during vector 7, then a clean rerun with the same vectors.
        @(negedge clk); start1 = 1'b1;
        step(); start1 = 1'b0;
        repeat (7) step();
        chk("mr_vec7", {vec1}, 8'd7);
        chk("mr_a7", {a1}, 4'h7);
        chk("mr_b7", {b1}, 4'hA);
        reset = 1'b0;
        step(); reset = 1'b1;
        chk("mr_busy", {busy1}, 1'b0);
        chk("mr_vec", {vec1}, 8'd0);
        chk("mr_err", {err1}, 8'd0);
        chk("mr_op", {op1}, 2'd0);
        chk("mr_a", {a1}, 4'd0);
        seen = 1'b0;
        repeat (20) begin seen |= done1; step(); end
        chk("mr_no_done", {seen}, 1'b0);
        @(negedge clk); start1 = 1'b1;
        step(); start1 = 1'b0;
        chk("re_op", {op1}, 2'd0);
        chk("re_a", {a1}, 4'h5);
        chk("re_b", {b1}, 4'hA);
        n = 0;
        while (!done1 && n < 40) begin step(); n++; end
        chk("re_done", {done1}, 1'b1);
        chk("re_err", {err1}, 8'd0);
        chk("re_vec", {vec1}, 8'd16);

        // 255 vectors against C stuck at 5'b10101.
        l = 8'hA5;
        n_err = 0;
        for (int i = 0; i < 255; i++) begin
            if (alu_fn(i[1:0], l[3:0], l[7:4]) != 5'b10101) n_err++;
            l = lfsr_step(l);
        end
        @(negedge clk); start2 = 1'b1;
        step(); start2 = 1'b0;
        n = 0;
        while (!done2 && n < 400) begin step(); n++; end
        chk("sat_done", {done2}, 1'b1);
        chk("sat_err", {err2}, n_err[7:0]);
        chk("sat_vec", {vec2}, 8'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
